// File: rtl/mem_arb_pkg.sv
// Shared state encoding, port indices and grant rule for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // On a tie the port that did not win last time gets the grant.
  function automatic logic pick_port(input logic i_req, input logic d_req,
                                     input logic last_grant);
    if (i_req && d_req) return ~last_grant;
    else if (d_req)     return PORT_D;
    else                return PORT_I;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Clearable saturating wait counter; expired marks the last cycle a memory access may wait.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int unsigned TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] LAST = LAST_I[TW-1:0];

  logic [TW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {TW{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  // TIMEOUT=0 never expires, so an access waits for mem_ready indefinitely.
  assign expired = (TIMEOUT > 0) && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store,
// with a bounded wait that returns an error response instead of stalling the core.
//
// state  | meaning
// IDLE   | sample i_req/d_req, grant one and launch mem_valid
// BUSY_I | fetch access outstanding, waiting for mem_ready or timeout
// BUSY_D | data access outstanding, waiting for mem_ready or timeout
// RESP   | one-cycle ack pulse to the granted port, no arbitration
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_ack,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_err,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic                    d_ack,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_err,
  output logic                    mem_valid,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy
);

  arb_state_t state;
  logic       last_grant;
  logic       grant_port;
  logic       in_busy;
  logic       expired;

  assign in_busy    = (state == BUSY_I) || (state == BUSY_D);
  assign grant_port = pick_port(i_req, d_req, last_grant);
  assign busy       = (state != IDLE);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == IDLE),
    .inc     (in_busy && !mem_ready),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= PORT_D;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      i_ack      <= 1'b0;
      i_rdata    <= '0;
      i_err      <= 1'b0;
      d_ack      <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            last_grant <= grant_port;
            mem_valid  <= 1'b1;
            if (grant_port == PORT_I) begin
              mem_we    <= 1'b0;
              mem_addr  <= i_addr;
              mem_wdata <= '0;
              mem_wstrb <= '0;
              state     <= BUSY_I;
            end else begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_wstrb <= d_we ? d_wstrb : '0;
              state     <= BUSY_D;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          // A ready on the expiry cycle still counts as a normal completion.
          if (mem_ready || expired) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            state     <= RESP;
            if (state == BUSY_I) begin
              i_ack   <= 1'b1;
              i_rdata <= mem_ready ? mem_rdata : '0;
              i_err   <= !mem_ready;
            end else begin
              d_ack   <= 1'b1;
              d_rdata <= (mem_ready && !mem_we) ? mem_rdata : '0;
              d_err   <= !mem_ready;
            end
          end
        end
        RESP: begin
          i_ack   <= 1'b0;
          i_rdata <= '0;
          i_err   <= 1'b0;
          d_ack   <= 1'b0;
          d_rdata <= '0;
          d_err   <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: directed cases plus randomized traffic against a
// transaction-level model of the arbitration, latency and timeout rules.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          i_err;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [SW-1:0] d_wstrb;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          d_err;
  logic          mem_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic idle_inputs();
    i_req = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    total++;
    if ({mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      bad++; $display("FAIL reset_mem: got %h want 0", {mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb});
    end
    total++;
    if ({i_ack, i_err, i_rdata, d_ack, d_err, d_rdata, busy} !== '0) begin
      bad++; $display("FAIL reset_resp: got %h want 0", {i_ack, i_err, i_rdata, d_ack, d_err, d_rdata, busy});
    end
    reset = 0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || mem_valid !== 1'b0) begin
      bad++; $display("FAIL reset_release: got busy=%b valid=%b want 0 0", busy, mem_valid);
    end
  endtask

  task automatic test_single_fetch();
    @(negedge clk);
    i_req = 1; i_addr = 32'h100; mem_ready = 1; mem_rdata = 32'h0050_0093;
    @(negedge clk);
    total++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || i_ack !== 1'b0) begin
      bad++; $display("FAIL fetch_issue: got valid=%b addr=%h we=%b ack=%b want 1 00000100 0 0",
                      mem_valid, mem_addr, mem_we, i_ack);
    end
    @(negedge clk);
    total++;
    if (i_ack !== 1'b1 || i_err !== 1'b0 || i_rdata !== 32'h0050_0093 || d_ack !== 1'b0 || mem_valid !== 1'b0) begin
      bad++; $display("FAIL fetch_ack: got ack=%b err=%b rdata=%h dack=%b valid=%b want 1 0 00500093 0 0",
                      i_ack, i_err, i_rdata, d_ack, mem_valid);
    end
    i_req = 0; mem_ready = 0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || i_ack !== 1'b0) begin
      bad++; $display("FAIL fetch_done: got busy=%b ack=%b want 0 0", busy, i_ack);
    end
  endtask

  task automatic test_store();
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
    mem_ready = 0; mem_rdata = 32'hA5A5_A5A5;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if ({mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 1'b1, 32'h2004, 32'hDEAD_BEEF, 4'b0011}) begin
        bad++; $display("FAIL store_fields[%0d]: got v=%b we=%b a=%h wd=%h st=%b want 1 1 00002004 deadbeef 0011",
                        k, mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb);
      end
      mem_ready = (k == 3);
    end
    @(negedge clk);
    total++;
    if (d_ack !== 1'b1 || d_rdata !== 32'h0 || d_err !== 1'b0 || i_ack !== 1'b0) begin
      bad++; $display("FAIL store_ack: got ack=%b rdata=%h err=%b iack=%b want 1 0 0 0", d_ack, d_rdata, d_err, i_ack);
    end
    d_req = 0; d_we = 0; mem_ready = 0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int  vcnt = 0;
    bit  seen = 0;
    @(negedge clk);
    d_req = 1; d_we = 0; d_addr = 32'h3000; mem_ready = 0; mem_rdata = 32'h1234_5678;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (d_ack) begin seen = 1; break; end
      if (mem_valid) vcnt++;
    end
    total++;
    if (!seen || vcnt != TO) begin
      bad++; $display("FAIL timeout_len: got ack_seen=%0d valid_cycles=%0d want 1 %0d", seen, vcnt, TO);
    end
    total++;
    if (d_err !== 1'b1 || d_rdata !== 32'h0) begin
      bad++; $display("FAIL timeout_resp: got err=%b rdata=%h want 1 0", d_err, d_rdata);
    end
    d_req = 0;
    @(negedge clk);
    i_req = 1; i_addr = 32'h104; mem_ready = 1; mem_rdata = 32'hCAFE_0001;
    @(negedge clk);
    total++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h104) begin
      bad++; $display("FAIL timeout_next_issue: got valid=%b addr=%h want 1 00000104", mem_valid, mem_addr);
    end
    @(negedge clk);
    total++;
    if (i_ack !== 1'b1 || i_err !== 1'b0 || i_rdata !== 32'hCAFE_0001) begin
      bad++; $display("FAIL timeout_next_ack: got ack=%b err=%b rdata=%h want 1 0 cafe0001", i_ack, i_err, i_rdata);
    end
    i_req = 0; mem_ready = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit got_ack = 0;
    bit seen = 0;
    @(negedge clk);
    d_req = 1; d_we = 0; d_addr = 32'h40; d_wdata = 32'h1; d_wstrb = 4'hF; mem_ready = 0;
    @(negedge clk);
    total++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h40 || busy !== 1'b1) begin
      bad++; $display("FAIL rstmid_busy: got valid=%b addr=%h busy=%b want 1 00000040 1", mem_valid, mem_addr, busy);
    end
    @(posedge clk);
    #2 reset = 1;
    #1;
    total++;
    if (mem_valid !== 1'b0 || busy !== 1'b0 || d_ack !== 1'b0) begin
      bad++; $display("FAIL rstmid_async: got valid=%b busy=%b ack=%b want 0 0 0", mem_valid, busy, d_ack);
    end
    repeat (2) begin
      @(negedge clk);
      if (d_ack || mem_valid) got_ack = 1;
    end
    total++;
    if (got_ack) begin
      bad++; $display("FAIL rstmid_no_ack: got activity=1 want 0");
    end
    i_req = 1; i_addr = 32'h200; mem_ready = 1; mem_rdata = 32'h77;
    reset = 0;
    @(negedge clk);
    total++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h200 || mem_we !== 1'b0) begin
      bad++; $display("FAIL rstmid_tie_fetch: got valid=%b addr=%h we=%b want 1 00000200 0", mem_valid, mem_addr, mem_we);
    end
    @(negedge clk);
    i_req = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (d_ack) begin seen = 1; break; end
    end
    total++;
    if (!seen || d_rdata !== 32'h77) begin
      bad++; $display("FAIL rstmid_data_served: got seen=%0d rdata=%h want 1 00000077", seen, d_rdata);
    end
    d_req = 0; mem_ready = 0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    int   order[$];
    bit   ri = 0, rd = 0, extra = 0;
    logic last;
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    i_req = 1; i_addr = 32'h400; d_req = 1; d_we = 1; d_addr = 32'h800; d_wdata = 32'h5; d_wstrb = 4'hF;
    mem_ready = 1;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      @(negedge clk);
      if (ri) begin i_req = 1; ri = 0; end
      if (rd) begin d_req = 1; rd = 0; end
      total++;
      if (i_ack && d_ack) begin
        bad++; $display("FAIL contention_both_ack: got i_ack=1 d_ack=1 want at most one");
      end
      if (i_ack) begin order.push_back(0); i_req = 0; ri = 1; end
      if (d_ack) begin order.push_back(1); d_req = 0; rd = 1; end
    end
    i_req = 0; d_req = 0;
    total++;
    if (order.size() != 4) begin
      bad++; $display("FAIL contention_count: got %0d acks want 4", order.size());
    end
    last = 1'b1;
    for (int j = 0; j < order.size(); j++) begin
      last = ~last;
      total++;
      if (order[j] != int'(last)) begin
        bad++; $display("FAIL contention_order[%0d]: got port %0d want %0d", j, order[j], last);
      end
    end
    repeat (4) begin
      @(negedge clk);
      if (mem_valid) extra = 1;
    end
    total++;
    if (extra) begin
      bad++; $display("FAIL contention_withdrawn: got extra grant=1 want 0");
    end
    mem_ready = 0;
  endtask

  task automatic test_stale();
    int issues = 0, acks = 0;
    bit prev = 0, drop = 0, seen = 0;
    @(negedge clk);
    i_req = 1; i_addr = 32'h300; mem_ready = 1; mem_rdata = 32'h99;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (drop) begin i_req = 0; drop = 0; end
      if (mem_valid && !prev) issues++;
      prev = mem_valid;
      if (i_ack) begin acks++; drop = 1; end
    end
    total++;
    if (issues != 1 || acks != 1) begin
      bad++; $display("FAIL stale_single: got issues=%0d acks=%0d want 1 1", issues, acks);
    end
    d_req = 1; d_we = 0; d_addr = 32'h500;
    @(negedge clk);
    total++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h500 || mem_we !== 1'b0) begin
      bad++; $display("FAIL stale_next_grant: got valid=%b addr=%h we=%b want 1 00000500 0", mem_valid, mem_addr, mem_we);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (d_ack) begin seen = 1; break; end
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL stale_next_ack: got no d_ack want d_ack");
    end
    d_req = 0; mem_ready = 0;
    @(negedge clk);
  endtask

  // Reference model: one outstanding transaction; grant by request presence and alternation,
  // ready after a random wait, error when the wait reaches TO cycles.
  task automatic test_random();
    int          phase = 0, nxt, k = 0, w = 0;
    logic        cur = 0, last, e_we = 0, e_err = 0, rdy;
    logic [31:0] e_addr = 0, e_wdata = 0, e_rdata = 0;
    logic [3:0]  e_wstrb = 0;
    logic [67:0] got_v, exp_v;
    @(negedge clk); reset = 1; idle_inputs();
    @(negedge clk); reset = 0;
    last = 1'b1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      got_v = {i_ack, i_err, i_rdata, d_ack, d_err, d_rdata};
      nxt = phase;
      if (phase == 0) begin
        total++;
        if (mem_valid !== (i_req || d_req)) begin
          bad++; $display("FAIL rand_grant: got valid=%b want %b (i_req=%b d_req=%b)", mem_valid, i_req || d_req, i_req, d_req);
        end
        if (mem_valid && (i_req || d_req)) begin
          cur  = (i_req && d_req) ? ~last : !i_req;
          last = cur;
          if (!cur) begin
            e_we = 0; e_addr = i_addr; e_wdata = 0; e_wstrb = 0;
          end else begin
            e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_wstrb = d_we ? d_wstrb : 4'h0;
          end
          k = 0; w = $urandom_range(0, 5);
          phase = 1; nxt = 1;
        end else begin
          total++;
          if (got_v !== '0 || busy !== 1'b0) begin
            bad++; $display("FAIL rand_idle: got resp=%h busy=%b want 0 0", got_v, busy);
          end
        end
      end
      if (phase == 1) begin
        total++;
        if (mem_valid !== 1'b1 || busy !== 1'b1 || mem_we !== e_we || mem_addr !== e_addr ||
            mem_wstrb !== e_wstrb || (e_we && mem_wdata !== e_wdata) || got_v !== '0) begin
          bad++; $display("FAIL rand_busy: got v=%b we=%b a=%h st=%h wd=%h resp=%h want 1 %b %h %h %h 0",
                          mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata, got_v, e_we, e_addr, e_wstrb, e_wdata);
        end
        rdy = (k == w);
        mem_ready = rdy;
        mem_rdata = $urandom;
        if (rdy || k == TO - 1) begin
          e_rdata = (rdy && !e_we) ? mem_rdata : 32'h0;
          e_err   = !rdy;
          nxt     = 2;
        end
        k++;
      end else if (phase == 2) begin
        exp_v = cur ? {1'b0, 1'b0, 32'h0, 1'b1, e_err, e_rdata} : {1'b1, e_err, e_rdata, 1'b0, 1'b0, 32'h0};
        total++;
        if (got_v !== exp_v || mem_valid !== 1'b0 || busy !== 1'b1) begin
          bad++; $display("FAIL rand_ack: got resp=%h valid=%b busy=%b want %h 0 1", got_v, mem_valid, busy, exp_v);
        end
        if (cur) d_req = 0; else i_req = 0;
        mem_ready = 1'($urandom_range(0, 1));
        nxt = 3;
      end else if (phase == 3) begin
        total++;
        if (mem_valid !== 1'b0 || busy !== 1'b0 || got_v !== '0) begin
          bad++; $display("FAIL rand_post: got valid=%b busy=%b resp=%h want 0 0 0", mem_valid, busy, got_v);
        end
        mem_ready = 1'($urandom_range(0, 1));
        nxt = 0;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      phase = nxt;
      if (!(phase != 0 && cur == 1'b0)) begin
        if (!i_req && $urandom_range(0, 2) == 0) begin
          i_req = 1; i_addr = $urandom & 32'hFFFF_FFFC;
        end else if (i_req && $urandom_range(0, 9) == 0) begin
          i_req = 0;
        end
      end
      if (!(phase != 0 && cur == 1'b1)) begin
        if (!d_req && $urandom_range(0, 2) == 0) begin
          d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom & 32'hFFFF_FFFC;
          d_wdata = $urandom; d_wstrb = 4'($urandom_range(0, 15));
        end else if (d_req && $urandom_range(0, 9) == 0) begin
          d_req = 0;
        end
      end
    end
    reset = 1;
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_store();
    test_timeout();
    test_reset_mid();
    test_contention();
    test_stale();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch path and the load/store data path of the multicycle RV32 core.
- Sits between the control/datapath and the memory model.
- Serialises requests with round-robin arbitration and a valid/ready handshake toward memory.
- Bounds memory waits with a timeout that returns an error response instead of hanging the core.

Parameters:
ADDR_WIDTH, 32, byte address width on all ports
DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
TIMEOUT, 64, max cycles mem_valid may stay high without mem_ready; 0 disables the timeout

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
i_req  in  1  fetch request; held with i_addr until i_ack
i_addr  in  ADDR_WIDTH  fetch address
i_ack  out  1  one-cycle response pulse for fetch
i_rdata  out  DATA_WIDTH  fetched word, valid while i_ack=1
i_err  out  1  fetch timed out, valid while i_ack=1
d_req  in  1  data request; held with the d_* inputs until d_ack
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_WIDTH  data address
d_wdata  in  DATA_WIDTH  store data
d_wstrb  in  DATA_WIDTH/8  store byte enables
d_ack  out  1  one-cycle response pulse for data
d_rdata  out  DATA_WIDTH  load data, valid while d_ack=1 (0 for stores)
d_err  out  1  data access timed out, valid while d_ack=1
mem_valid  out  1  memory request valid
mem_we  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_wstrb  out  DATA_WIDTH/8  memory byte enables; 0 on reads
mem_ready  in  1  memory accepts/completes the access this cycle
mem_rdata  in  DATA_WIDTH  read data, valid when mem_ready=1
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - state=IDLE, last_grant=DATA (so the fetch port wins the first tie).
  - All outputs 0, timer 0.
  - Reset asserted mid-access drops mem_valid asynchronously and abandons the access; no ack is issued.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
  - IDLE: evaluate requests.
    - Only one request → grant it.
    - Both requesting → grant the port not equal to last_grant.
    - On grant: latch the request fields into the mem_* registers, set mem_valid=1, update last_grant, go to BUSY_I or BUSY_D.
    - No request → stay in IDLE.
  - BUSY_x: mem_* outputs stay registered and stable.
    - mem_ready=1 → capture mem_rdata (stores capture 0), clear mem_valid, err=0, go to RESP.
    - Timeout: if TIMEOUT>0 and the timer reaches TIMEOUT-1 with mem_ready=0 → clear mem_valid, rdata=0, err=1, go to RESP.
    - If mem_ready is high on the timeout cycle, it completes normally.
  - RESP: pulse x_ack=1 for exactly one cycle with x_rdata and x_err, then go to IDLE. No arbitration happens in RESP, so a stale req is never re-granted.
- Timer:
  - Width $clog2(TIMEOUT+1), minimum 1 bit.
  - Cleared on entry to BUSY_x; increments each BUSY cycle with mem_ready=0; saturates.
- Latency:
  - Request sampled in IDLE at cycle N → mem_valid high from N+1.
  - mem_ready at cycle M → ack at M+1, IDLE at M+2.
  - Minimum fetch-to-ack is 2 cycles; minimum back-to-back issue interval is 3 cycles.
- Outputs for a non-granted port stay 0. i_ack and d_ack are never high together.
- Requesters must not change the request fields while req is high and no ack has been received. The arbiter latches them at grant and ignores later changes.
- A request deasserted before grant is simply not served. A request deasserted after grant still completes and acks.

Decomposition:
- Package mem_arb_pkg holds:
  - the state encoding (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2, RESP=2'd3);
  - the port index constants (PORT_I=1'b0, PORT_D=1'b1).
- One sub-module, mem_wait_timer: a clearable saturating counter with an expired flag, parameterised by TIMEOUT, with TIMEOUT=0 tied to never-expire.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, mem_ready on the 1st valid cycle with rdata=0x00500093 → mem_valid at N+1 with addr 0x100 and we=0; i_ack at N+2 with i_rdata=0x00500093 and i_err=0; busy low at N+3.
- Store: d_req=1, d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_wstrb=4'b0011, 3 wait cycles → mem_* fields match and stay stable for 4 cycles; d_ack with d_rdata=0 and d_err=0.
- Contention: i_req and d_req both held after reset → grant order I, D, I, D, with acks alternating and never simultaneous.
- Timeout: TIMEOUT=4, d_req load, mem_ready held low → mem_valid high for exactly 4 cycles, then d_ack=1, d_err=1, d_rdata=0; the next fetch is served normally.
- Reset mid-access: assert reset during BUSY_D between clock edges → mem_valid and busy drop immediately without a clock; no d_ack; after release, the first tie is granted to fetch.
- Stale request: keep i_req high for 1 cycle past i_ack → exactly one fetch is issued, and the next grant occurs only after the IDLE re-sample.
